inst_fetch_buffer: RTL

- Decoupling FIFO between the IF stage (PC/inst-SRAM output registers) and the ID stage.
- Captures each fetched {pc, inst, delay-slot flag, exception vector} and presents them in order to decode.
- Fetch can run ahead while ID stalls; a pipeline flush empties it in one cycle.

---
 rtl/inst_fetch_buffer_pkg.sv | 16 +
 rtl/inst_fetch_buffer_mem.sv | 26 ++
 rtl/inst_fetch_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and sizing for the instruction fetch buffer between IF and ID.
package inst_fetch_buffer_pkg;

    localparam int EXC_W      = 16;
    localparam int IBUF_DEPTH = 4;
    localparam int IBUF_PTR_W = 2;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             inslot;
        logic [EXC_W-1:0] excs;
        logic             has_exc;
    } ibuf_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_mem.sv
// Entry storage for the fetch buffer: one write port, one asynchronous read port, no reset.
module ibuf_mem
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int PTR_W = IBUF_PTR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  ibuf_entry_t      wdata,
    input  logic [PTR_W-1:0] raddr,
    output ibuf_entry_t      rdata
);

    ibuf_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// In-order IF->ID decoupling FIFO with first-word fall-through and single-cycle flush.
// Optional macro IBUF_PERF_EN adds saturating full/empty-stall cycle counters.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int PTR_W = IBUF_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [31:0]      in_pc_i,
    input  logic [31:0]      in_inst_i,
    input  logic             in_inslot_i,
    input  logic [EXC_W-1:0] in_excs_i,
    input  logic             in_has_exc_i,
    output logic             in_ready_o,
    output logic             id_valid_o,
    output logic [31:0]      id_pc_o,
    output logic [31:0]      id_inst_o,
    output logic             id_inslot_o,
    output logic [EXC_W-1:0] id_excs_o,
    output logic             id_has_exc_o,
    input  logic             id_ready_i,
    output logic [PTR_W:0]   count_o
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]      full_cycles_o,
    output logic [31:0]      empty_stall_cycles_o
`endif
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    ibuf_entry_t      wr_entry;
    ibuf_entry_t      head;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    // Ready never looks at id_ready_i: a full buffer blocks push even on a pop cycle.
    assign in_ready_o = rst_n & ~full;
    assign id_valid_o = ~empty;
    assign push       = in_valid_i & in_ready_o;
    assign pop        = id_valid_o & id_ready_i;
    assign count_o    = count;

    assign wr_entry = '{pc: in_pc_i, inst: in_inst_i, inslot: in_inslot_i,
                        excs: in_excs_i, has_exc: in_has_exc_i};

    ibuf_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush_i),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_comb begin
        id_pc_o      = '0;
        id_inst_o    = '0;
        id_inslot_o  = 1'b0;
        id_excs_o    = '0;
        id_has_exc_o = 1'b0;
        if (id_valid_o) begin
            id_pc_o      = head.pc;
            id_inst_o    = head.inst;
            id_inslot_o  = head.inslot;
            id_excs_o    = head.excs;
            id_has_exc_o = head.has_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef IBUF_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_cycles_o        <= '0;
            empty_stall_cycles_o <= '0;
        end else begin
            if (full && in_valid_i) begin
                full_cycles_o <= sat_inc(full_cycles_o);
            end
            if (empty && id_ready_i) begin
                empty_stall_cycles_o <= sat_inc(empty_stall_cycles_o);
            end
        end
    end
`endif

endmodule
